wb_flash_arbiter: RTL and testbench

- Two-master Wishbone arbiter in front of the single wb_flash_sword slave port.
- Master 0 is the instruction-fetch bus; master 1 is the data bus (loads/stores, flash programming).
- Grants the flash to one master per Wishbone cycle (whole cyc_i burst) and holds off new grants while the flash reports busy.
- Routes ack/data back only to the granted master.

---
 rtl/wb_flash_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_wb_flash_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_flash_arbiter.sv
// Two-master Wishbone arbiter in front of the single flash slave port.
// Master 0 is instruction fetch, master 1 is the data bus. Ownership lasts a whole
// cyc burst, new grants are held off while the flash is busy, and every ownership
// change passes through one IDLE cycle.
// Optional build macro: WB_FLASH_ARB_WATCHDOG_EN adds a slave-ack watchdog that
// errors the owner after TIMEOUT_CYCLES unacknowledged strobe cycles.
module wb_flash_arbiter #(
  parameter bit          PRIORITY_M0    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_BITS       = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flash_busy,
  // master 0: instruction fetch
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [29:0] m0_addr_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1: data bus
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [29:0] m1_addr_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // flash slave
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [29:0] s_addr_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  // one-hot owner, 00 = idle
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_owner_q, last_owner_d;

  logic own0;
  logic own1;
  logic timeout;  // watchdog expired: abort the current owner this cycle

  // Forwarding muxes key off the registered grant only.
  assign own0  = grant_q[0];
  assign own1  = grant_q[1];
  assign grant = grant_q;

`ifdef WB_FLASH_ARB_WATCHDOG_EN
  logic [CNT_BITS-1:0] wd_cnt_q, wd_cnt_d;
  logic                owner_stb;

  assign owner_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);
  assign timeout   = (own0 | own1) && (wd_cnt_q == CNT_BITS'(TIMEOUT_CYCLES));

  // Count unacknowledged strobe cycles while ownership continues; clear otherwise.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q != StIdle && state_d == state_q && owner_stb && !s_ack_i) begin
      wd_cnt_d = wd_cnt_q + CNT_BITS'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  // Without the watchdog a hung slave stalls the owner indefinitely.
  assign timeout = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_BITS};
`endif

  // State, grant and tie-break history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= 2'b00;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Arbitration: grant only from IDLE, release when the owner drops cyc or times out.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      StIdle: begin
        if (!flash_busy) begin
          if (m0_cyc_i && m1_cyc_i) begin
            // Round-robin tie-break: the master that owned last loses.
            state_d = (PRIORITY_M0 || last_owner_q) ? StOwn0 : StOwn1;
          end else if (m0_cyc_i) begin
            state_d = StOwn0;
          end else if (m1_cyc_i) begin
            state_d = StOwn1;
          end
        end
      end
      StOwn0: begin
        if (!m0_cyc_i || timeout) begin
          state_d      = StIdle;
          last_owner_d = 1'b0;
        end
      end
      StOwn1: begin
        if (!m1_cyc_i || timeout) begin
          state_d      = StIdle;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    grant_d = {state_d == StOwn1, state_d == StOwn0};
  end

  // Bus routing: owner drives the slave, slave responses go back to the owner only.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    s_sel_o   = '0;
    s_data_o  = '0;
    m0_data_o = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    if (own0) begin
      s_cyc_o   = m0_cyc_i & ~timeout;
      s_stb_o   = m0_stb_i & ~timeout;
      s_we_o    = m0_we_i;
      s_addr_o  = m0_addr_i;
      s_cti_o   = m0_cti_i;
      s_bte_o   = m0_bte_i;
      s_sel_o   = m0_sel_i;
      s_data_o  = m0_data_i;
      m0_data_o = s_data_i;
      m0_ack_o  = s_ack_i & ~timeout;
      m0_err_o  = timeout;
    end else if (own1) begin
      s_cyc_o   = m1_cyc_i & ~timeout;
      s_stb_o   = m1_stb_i & ~timeout;
      s_we_o    = m1_we_i;
      s_addr_o  = m1_addr_i;
      s_cti_o   = m1_cti_i;
      s_bte_o   = m1_bte_i;
      s_sel_o   = m1_sel_i;
      s_data_o  = m1_data_i;
      m1_data_o = s_data_i;
      m1_ack_o  = s_ack_i & ~timeout;
      m1_err_o  = timeout;
    end
  end

endmodule

// File: tb/tb_wb_flash_arbiter.sv
// Bench for wb_flash_arbiter: a fixed-priority and a round-robin instance share the
// same stimulus; a behavioural owner model checks every output on each falling edge,
// and directed steps pin the expected grant/ack/err values by hand.
module tb_wb_flash_arbiter;

  localparam int TMO = 8;
`ifdef WB_FLASH_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flash_busy;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [29:0] m0_addr, m1_addr;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_wdat, m1_wdat, s_rdat;
  logic        s_ack;

  // index 0: PRIORITY_M0 = 1, index 1: round-robin
  logic [31:0] m0_rdat [2];
  logic [31:0] m1_rdat [2];
  logic        m0_ack [2];
  logic        m0_err [2];
  logic        m1_ack [2];
  logic        m1_err [2];
  logic        s_cyc [2];
  logic        s_stb [2];
  logic        s_we [2];
  logic [29:0] s_addr [2];
  logic [2:0]  s_cti [2];
  logic [1:0]  s_bte [2];
  logic [3:0]  s_sel [2];
  logic [31:0] s_wdat [2];
  logic [1:0]  grant [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_flash_arbiter #(.PRIORITY_M0(1'b1), .TIMEOUT_CYCLES(TMO), .CNT_BITS(4)) dut_pri (
    .clk(clk), .rst_n(rst_n), .flash_busy(flash_busy),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_addr_i(m0_addr), .m0_cti_i(m0_cti),
    .m0_bte_i(m0_bte), .m0_sel_i(m0_sel), .m0_we_i(m0_we), .m0_data_i(m0_wdat),
    .m0_data_o(m0_rdat[0]), .m0_ack_o(m0_ack[0]), .m0_err_o(m0_err[0]),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_addr_i(m1_addr), .m1_cti_i(m1_cti),
    .m1_bte_i(m1_bte), .m1_sel_i(m1_sel), .m1_we_i(m1_we), .m1_data_i(m1_wdat),
    .m1_data_o(m1_rdat[0]), .m1_ack_o(m1_ack[0]), .m1_err_o(m1_err[0]),
    .s_cyc_o(s_cyc[0]), .s_stb_o(s_stb[0]), .s_we_o(s_we[0]), .s_addr_o(s_addr[0]),
    .s_cti_o(s_cti[0]), .s_bte_o(s_bte[0]), .s_sel_o(s_sel[0]), .s_data_o(s_wdat[0]),
    .s_data_i(s_rdat), .s_ack_i(s_ack), .grant(grant[0])
  );

  wb_flash_arbiter #(.PRIORITY_M0(1'b0), .TIMEOUT_CYCLES(TMO), .CNT_BITS(4)) dut_rr (
    .clk(clk), .rst_n(rst_n), .flash_busy(flash_busy),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_addr_i(m0_addr), .m0_cti_i(m0_cti),
    .m0_bte_i(m0_bte), .m0_sel_i(m0_sel), .m0_we_i(m0_we), .m0_data_i(m0_wdat),
    .m0_data_o(m0_rdat[1]), .m0_ack_o(m0_ack[1]), .m0_err_o(m0_err[1]),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_addr_i(m1_addr), .m1_cti_i(m1_cti),
    .m1_bte_i(m1_bte), .m1_sel_i(m1_sel), .m1_we_i(m1_we), .m1_data_i(m1_wdat),
    .m1_data_o(m1_rdat[1]), .m1_ack_o(m1_ack[1]), .m1_err_o(m1_err[1]),
    .s_cyc_o(s_cyc[1]), .s_stb_o(s_stb[1]), .s_we_o(s_we[1]), .s_addr_o(s_addr[1]),
    .s_cti_o(s_cti[1]), .s_bte_o(s_bte[1]), .s_sel_o(s_sel[1]), .s_data_o(s_wdat[1]),
    .s_data_i(s_rdat), .s_ack_i(s_ack), .grant(grant[1])
  );

  // ---------------- behavioural model ----------------
  // owner: -1 idle, 0 / 1 = master index; last: previous owner; wd: unacked stb cycles
  int own_q [2] = '{-1, -1};
  int last_q [2] = '{1, 1};
  int wd_q [2] = '{0, 0};

  function automatic bit cyc_of(input int x);
    return (x == 0) ? m0_cyc : m1_cyc;
  endfunction

  function automatic bit stb_of(input int x);
    return (x == 0) ? m0_stb : m1_stb;
  endfunction

  function automatic bit timed_out(input int k);
    return WD && own_q[k] >= 0 && wd_q[k] == TMO;
  endfunction

  function automatic bit releasing(input int k);
    return own_q[k] >= 0 && (!cyc_of(own_q[k]) || timed_out(k));
  endfunction

  function automatic int nx_own(input int k);
    if (own_q[k] < 0) begin
      if (flash_busy) return -1;
      if (m0_cyc && m1_cyc) return (k == 0) ? 0 : ((last_q[k] == 0) ? 1 : 0);
      if (m0_cyc) return 0;
      if (m1_cyc) return 1;
      return -1;
    end
    return releasing(k) ? -1 : own_q[k];
  endfunction

  function automatic int nx_last(input int k);
    return releasing(k) ? own_q[k] : last_q[k];
  endfunction

  function automatic int nx_wd(input int k);
    if (own_q[k] < 0 || releasing(k)) return 0;
    return (stb_of(own_q[k]) && !s_ack) ? wd_q[k] + 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        own_q[k]  <= -1;
        last_q[k] <= 1;
        wd_q[k]   <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        own_q[k]  <= nx_own(k);
        last_q[k] <= nx_last(k);
        wd_q[k]   <= nx_wd(k);
      end
    end
  end

  function automatic logic [73:0] exp_s(input int k);
    logic to;
    to = timed_out(k);
    if (own_q[k] == 0)
      return {m0_cyc & ~to, m0_stb & ~to, m0_we, m0_addr, m0_cti, m0_bte, m0_sel, m0_wdat};
    if (own_q[k] == 1)
      return {m1_cyc & ~to, m1_stb & ~to, m1_we, m1_addr, m1_cti, m1_bte, m1_sel, m1_wdat};
    return '0;
  endfunction

  function automatic logic [33:0] exp_m(input int k, input int x);
    logic to;
    to = timed_out(k);
    if (own_q[k] == x) return {s_ack & ~to, to, s_rdat};
    return '0;
  endfunction

  function automatic logic [1:0] exp_g(input int k);
    if (own_q[k] == 0) return 2'b01;
    if (own_q[k] == 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model compare on every falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("mdl_slave[%0d]", k),
          {s_cyc[k], s_stb[k], s_we[k], s_addr[k], s_cti[k], s_bte[k], s_sel[k], s_wdat[k]},
          exp_s(k));
      chk($sformatf("mdl_m0[%0d]", k), {m0_ack[k], m0_err[k], m0_rdat[k]}, exp_m(k, 0));
      chk($sformatf("mdl_m1[%0d]", k), {m1_ack[k], m1_err[k], m1_rdat[k]}, exp_m(k, 1));
      chk($sformatf("mdl_grant[%0d]", k), grant[k], exp_g(k));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] rr_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; flash_busy = 1'b0; s_ack = 1'b0; s_rdat = '0;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = '0; m0_cti = '0; m0_bte = '0;
    m0_sel = 4'hF; m0_wdat = 32'hA0A0_0000;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = '0; m1_cti = '0; m1_bte = '0;
    m1_sel = 4'hF; m1_wdat = 32'hB1B1_0000;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_grant", grant[0], 2'b00);
    chk("rst_scyc", s_cyc[0], 1'b0);
    chk("rst_rr_grant", grant[1], 2'b00);

    // single read from m1
    m1_cyc = 1; m1_stb = 1; m1_addr = 30'h100;
    tick();
    chk("rd_grant", grant[0], 2'b10);
    tick(); tick();
    s_ack = 1; s_rdat = 32'hDEADBEEF;
    #1;
    chk("rd_ack", m1_ack[0], 1'b1);
    chk("rd_data", m1_rdat[0], 32'hDEADBEEF);
    chk("rd_m0_noack", m0_ack[0], 1'b0);
    tick();
    s_ack = 0; s_rdat = '0; m1_cyc = 0; m1_stb = 0;
    tick();
    chk("rd_idle", grant[0], 2'b00);

    // contention: both request together, m0 wins on both instances (last owner = m1)
    m0_cyc = 1; m0_stb = 1; m0_addr = 30'h200; m1_cyc = 1; m1_stb = 1;
    tick();
    chk("ct_grant_pri", grant[0], 2'b01);
    chk("ct_grant_rr", grant[1], 2'b01);
    s_ack = 1; s_rdat = 32'h1111_0000;
    #1;
    chk("ct_acks", {m1_ack[0], m0_ack[0]}, 2'b01);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();
    chk("ct_turnaround", grant[0], 2'b00);
    tick();
    chk("ct_grant_m1", grant[0], 2'b10);
    m1_cyc = 0; m1_stb = 0;
    tick();

    // round-robin with both held requesting, starting from reset history
    rst_n = 0; #2; rst_n = 1;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr_grant%0d", i), grant[1], rr_seq[i]);
      s_ack = 1; s_rdat = 32'hC000_0000 + i;
      #1;
      chk($sformatf("rr_ack%0d", i), {m1_ack[1], m0_ack[1]}, rr_seq[i]);
      tick();
      s_ack = 0;
      if (rr_seq[i][0]) begin m0_cyc = 0; m0_stb = 0; end
      else begin m1_cyc = 0; m1_stb = 0; end
      tick();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    end
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick(); tick();

    // busy hold-off
    flash_busy = 1; m0_cyc = 1; m0_stb = 1; m0_addr = 30'h300;
    repeat (20) begin
      tick();
      chk("busy_scyc", s_cyc[0], 1'b0);
    end
    flash_busy = 0;
    tick();
    chk("busy_grant", grant[0], 2'b01);
    chk("busy_scyc_on", s_cyc[0], 1'b1);
    m0_cyc = 0; m0_stb = 0;
    tick();

    // 4-beat incrementing burst on m0 with m1 waiting
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_cti = 3'b010; m0_addr = 30'h400;
    tick();
    m1_cyc = 1; m1_stb = 1;
    for (int b = 0; b < 4; b++) begin
      m0_addr = 30'h400 + 30'(b);
      m0_cti = (b == 3) ? 3'b111 : 3'b010;
      m0_wdat = 32'hA0A0_0000 + b;
      s_ack = 1; s_rdat = 32'hB000_0000 + b;
      #1;
      chk("bst_grant", grant[0], 2'b01);
      chk("bst_grant_rr", grant[1], 2'b01);
      chk("bst_acks", {m1_ack[0], m0_ack[0]}, 2'b01);
      tick();
    end
    s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_cti = '0;
    tick();
    chk("bst_idle", grant[0], 2'b00);
    tick();
    chk("bst_m1_grant", grant[0], 2'b10);
    m1_cyc = 0; m1_stb = 0;
    tick();

    // hung slave
    m0_cyc = 1; m0_stb = 1; m0_addr = 30'h500;
    tick();
    chk("wd_grant", grant[0], 2'b01);
`ifdef WB_FLASH_ARB_WATCHDOG_EN
    repeat (TMO - 1) begin
      tick();
      chk("wd_noerr", m0_err[0], 1'b0);
    end
    tick();
    chk("wd_err", m0_err[0], 1'b1);
    chk("wd_scyc_forced", s_cyc[0], 1'b0);
    m0_cyc = 0; m0_stb = 0;
    tick();
    chk("wd_err_pulse", m0_err[0], 1'b0);
    chk("wd_idle", grant[0], 2'b00);
`else
    repeat (12) tick();
    chk("nowd_grant", grant[0], 2'b01);
    chk("nowd_err", m0_err[0], 1'b0);
    m0_cyc = 0; m0_stb = 0;
    tick();
`endif
    tick();

    // async reset in the middle of a burst
    m0_cyc = 1; m0_stb = 1; m0_cti = 3'b010;
    tick();
    s_ack = 1;
    tick();
    #2 rst_n = 0;
    #1;
    chk("arst_grant", grant[0], 2'b00);
    chk("arst_grant_rr", grant[1], 2'b00);
    chk("arst_scyc", s_cyc[0], 1'b0);
    chk("arst_ack", m0_ack[0], 1'b0);
    s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_cti = '0;
    tick();
    rst_n = 1;
    tick();
    chk("arst_after", grant[0], 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running want finished");
    $fatal(1, "simulation time limit");
  end

endmodule
